serial_adder: RTL

Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell and a carry flop. It accepts a parallel operand pair and carry-in on a start pulse, and shifts the operands LSB-first through the cell, one bit per cycle. It returns the parallel sum and carry-out with a one-cycle done pulse. It is the sequencing stage that drives the one-bit full adder, trading WIDTH cycles of latency for one adder cell.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_fa_bit.sv | 14 +
 rtl/serial_adder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding, default operand width and the counter-width helper.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_t;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit combinational full adder: the single arithmetic cell
// that the serial adder reuses once per operand bit.
module serial_fa_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_co
);

   assign o_s  = i_a ^ i_b ^ i_cin;
   assign o_co = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output o_ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   localparam int unsigned        CntW    = clog2(WIDTH);
   localparam logic [CntW-1:0]    LastCnt = CntW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_carry;
   logic [CntW-1:0]  r_cnt;

   logic             w_s;
   logic             w_co;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] w_res_cat;

   serial_fa_bit u_fa (
      .i_a   (r_a[0]),
      .i_b   (r_b[0]),
      .i_cin (r_carry),
      .o_s   (w_s),
      .o_co  (w_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts the word is complete.
   assign w_res_cat = {w_s, r_res};

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_start) begin
               w_next = StShift;
               w_load = 1'b1;
            end
         end
         StShift: begin
            if (r_cnt == LastCnt) w_next = StDone;
         end
         StDone: begin
            w_next = i_start ? StShift : StIdle;
            w_load = i_start;
         end
         default: w_next = StIdle;
      endcase
   end

   assign w_last = (r_state == StShift) && (r_cnt == LastCnt);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_a     <= i_a;
         r_b     <= i_b;
         r_carry <= i_cin;
         r_cnt   <= '0;
      end else if (r_state == StShift) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_res   <= w_res_cat[WIDTH-1:1];
         r_carry <= w_co;
         r_cnt   <= r_cnt + CntW'(1);
      end
   end

   // Host-visible result only changes on entry to DONE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (w_last) begin
         r_sum  <= w_res_cat;
         r_cout <= w_co;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the final shift r_carry is the carry into the MSB, w_co the carry out.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= r_carry ^ w_co;
      end
   end

   assign o_ovf = r_ovf;
`endif

   assign o_busy = (r_state == StShift);
   assign o_done = (r_state == StDone);
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule
